// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and bubble word.
package if_stage_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2,
    S_DROP = 2'd3
  } if_state_e;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a new entry, hold while decode stalls, else bubble.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(if_stage_pkg::NOP_INSTR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  load_i,
  input  logic                  hold_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] inc_pc_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] inc_pc_o
);
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] instr_q, pc_q, inc_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      instr_q  <= NOP_INSTR;
      pc_q     <= '0;
      inc_pc_q <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (load_i) begin
      valid_q  <= 1'b1;
      instr_q  <= instr_i;
      pc_q     <= pc_i;
      inc_pc_q <= inc_pc_i;
    end else if (!hold_i) begin
      // Nothing delivered and decode is draining: insert a bubble.
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end
  end

  assign valid_o  = valid_q;
  assign instr_o  = instr_q;
  assign pc_o     = pc_q;
  assign inc_pc_o = inc_pc_q;
endmodule

// File: rtl/if_stage.sv
// Instruction fetch: one outstanding imem read, one-entry skid buffer, flush/drop handling.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(if_stage_pkg::NOP_INSTR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] inc_pc_i,
  output logic                  pc_stall_o,
  input  logic                  flush_i,
  input  logic                  stall_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ready_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] inc_pc_o
);
  if_state_e             state_q;
  logic [DATA_WIDTH-1:0] tag_pc_q, tag_inc_q;
  logic                  skid_v_q;
  logic [DATA_WIDTH-1:0] skid_instr_q, skid_pc_q, skid_inc_q;

  logic                  ifid_free, dlv_wait, dlv_full, accept;
  logic                  load_d, hold_d;
  logic [DATA_WIDTH-1:0] ld_instr_d, ld_pc_d, ld_inc_d;

  assign ifid_free = !stall_i || !valid_o;
  assign dlv_wait  = (state_q == S_WAIT) && imem_rvalid_i && !flush_i && ifid_free;
  assign dlv_full  = (state_q == S_FULL) && skid_v_q && !stall_i && !flush_i;

  // The response cycle may also issue the next read, so a zero-wait cache streams one per cycle.
  assign imem_req_o  = !rst && !flush_i && ((state_q == S_REQ) || dlv_wait);
  assign imem_addr_o = pc_i;
  assign accept      = imem_req_o && imem_ready_i;
  assign pc_stall_o  = rst || !(accept || flush_i);

  assign load_d     = dlv_wait || dlv_full;
  assign hold_d     = stall_i && valid_o;
  assign ld_instr_d = dlv_full ? skid_instr_q : imem_rdata_i;
  assign ld_pc_d    = dlv_full ? skid_pc_q    : tag_pc_q;
  assign ld_inc_d   = dlv_full ? skid_inc_q   : tag_inc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      tag_pc_q     <= '0;
      tag_inc_q    <= '0;
      skid_v_q     <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_inc_q   <= '0;
    end else begin
      if (accept) begin
        tag_pc_q  <= pc_i;
        tag_inc_q <= inc_pc_i;
      end
      case (state_q)
        S_REQ: if (accept) state_q <= S_WAIT;
        S_WAIT: begin
          if (flush_i)
            state_q <= imem_rvalid_i ? S_REQ : S_DROP;
          else if (imem_rvalid_i) begin
            if (ifid_free)
              state_q <= accept ? S_WAIT : S_REQ;
            else begin
              skid_v_q     <= 1'b1;
              skid_instr_q <= imem_rdata_i;
              skid_pc_q    <= tag_pc_q;
              skid_inc_q   <= tag_inc_q;
              state_q      <= S_FULL;
            end
          end
        end
        S_FULL: if (flush_i || !stall_i) begin
          skid_v_q <= 1'b0;
          state_q  <= S_REQ;
        end
        S_DROP: if (imem_rvalid_i) state_q <= S_REQ;
        default: state_q <= S_REQ;
      endcase
    end
  end

  if_id_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .load_i  (load_d),
    .hold_i  (hold_d),
    .instr_i (ld_instr_d),
    .pc_i    (ld_pc_d),
    .inc_pc_i(ld_inc_d),
    .valid_o (valid_o),
    .instr_o (instr_o),
    .pc_o    (pc_o),
    .inc_pc_o(inc_pc_o)
  );
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: PC stage + cache model, in-order delivery scoreboard, directed and random steps.
module tb_if_stage;
  localparam int W = 32;
  localparam logic [W-1:0] NOP = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pc_i, inc_pc_i, imem_addr_o, imem_rdata_i, instr_o, pc_o, inc_pc_o;
  logic         pc_stall_o, flush_i, stall_i, imem_req_o, imem_ready_i, imem_rvalid_i, valid_o;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .inc_pc_i(inc_pc_i), .pc_stall_o(pc_stall_o),
    .flush_i(flush_i), .stall_i(stall_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o), .inc_pc_o(inc_pc_o)
  );

  int checks = 0, failures = 0;

  // Reference state: PC stage, single-slot cache, and ordered list of fetched-but-undelivered PCs.
  logic [W-1:0] pc_q;
  logic         pend_v;
  logic [W-1:0] pend_addr;
  int           pend_cnt;
  logic [W-1:0] expq[$];

  logic         k_flush, k_stall, k_ready, k_unsol;
  logic [W-1:0] k_tgt;
  int           k_lat;
  logic         last_ps, last_req;

  function automatic logic [W-1:0] mem(input logic [W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic         sol, acc, hv, hs, hf;
    logic [W-1:0] hi, hp, hn, pcc, e;
    pc_i          = pc_q;
    inc_pc_i      = pc_q + 32'd4;
    flush_i       = k_flush;
    stall_i       = k_stall;
    imem_ready_i  = k_ready;
    sol           = pend_v && (pend_cnt == 0);
    imem_rvalid_i = sol || (!pend_v && k_unsol);
    imem_rdata_i  = sol ? mem(pend_addr) : $urandom();
    #1;
    acc      = imem_req_o && imem_ready_i;
    last_ps  = pc_stall_o;
    last_req = imem_req_o;
    chk("pc_stall", 32'(pc_stall_o), 32'(!(acc || k_flush)));
    if (imem_req_o) chk("imem_addr", imem_addr_o, pc_i);
    if (imem_req_o && pend_v) chk("one_outstanding", 32'(sol), 32'd1);
    if (k_flush) chk("req_in_flush", 32'(imem_req_o), 32'd0);
    hv = valid_o; hs = k_stall; hf = k_flush;
    hi = instr_o; hp = pc_o; hn = inc_pc_o; pcc = pc_i;
    @(posedge clk);
    #1;
    if (!last_ps) pc_q = hf ? k_tgt : pc_q + 32'd4;
    if (sol) pend_v = 1'b0;
    else if (pend_v) pend_cnt--;
    if (acc) begin
      pend_v = 1'b1; pend_addr = pcc; pend_cnt = k_lat;
    end
    if (hf) begin
      expq.delete();
      chk("flush_valid", 32'(valid_o), 32'd0);
      chk("flush_nop", instr_o, NOP);
    end else if (hv && hs) begin
      chk("hold_valid", 32'(valid_o), 32'd1);
      chk("hold_instr", instr_o, hi);
      chk("hold_pc", pc_o, hp);
      chk("hold_inc", inc_pc_o, hn);
    end else if (valid_o) begin
      chk("deliver_expected", 32'(expq.size() > 0), 32'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("deliver_pc", pc_o, e);
        chk("deliver_instr", instr_o, mem(e));
        chk("deliver_inc", inc_pc_o, e + 32'd4);
      end
    end else begin
      chk("bubble_nop", instr_o, NOP);
    end
    if (acc) expq.push_back(pcc);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0; imem_ready_i = 1'b1;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0; pc_i = 32'h40; inc_pc_i = 32'h44;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_instr", instr_o, NOP);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_inc", inc_pc_o, 32'd0);
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_stall", 32'(pc_stall_o), 32'd1);
    rst = 1'b0;
    pc_q = '0; pend_v = 1'b0; pend_cnt = 0; expq.delete();
  endtask

  task automatic knobs(input logic f, input logic s, input logic r, input int lat);
    k_flush = f; k_stall = s; k_ready = r; k_lat = lat; k_unsol = 1'b0;
  endtask

  initial begin
    k_tgt = '0;
    knobs(0, 0, 0, 0);
    do_reset();

    // Zero-wait cache streaming from PC 0.
    knobs(0, 0, 1, 0);
    step();
    chk("zw_first_nostall", 32'(last_ps), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("zw_nostall", 32'(last_ps), 32'd0);
      chk("zw_valid", 32'(valid_o), 32'd1);
      chk("zw_pc", pc_o, 32'(i * 4));
    end

    // Three-cycle latency at 0x10.
    k_tgt = 32'h10; knobs(1, 0, 1, 0); step();
    knobs(0, 0, 1, 2); step();
    k_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lat_stall", 32'(last_ps), 32'd1);
    end
    chk("lat_valid", 32'(valid_o), 32'd1);
    chk("lat_instr", instr_o, mem(32'h10));
    chk("lat_pc", pc_o, 32'h10);
    chk("lat_inc", inc_pc_o, 32'h14);

    // Decode stall with 0x1C held while 0x20 arrives.
    k_tgt = 32'h1C; knobs(1, 0, 1, 0); step();
    knobs(0, 0, 1, 0); step(); step();
    knobs(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_hold_pc", pc_o, 32'h1C);
      chk("stall_hold_instr", instr_o, mem(32'h1C));
    end
    knobs(0, 0, 0, 0); step();
    chk("stall_release_pc", pc_o, 32'h20);
    chk("stall_release_valid", 32'(valid_o), 32'd1);
    step();
    chk("stall_no_dup", 32'(valid_o), 32'd0);

    // Flush while waiting on 0x30; redirect to 0x100.
    k_tgt = 32'h30; knobs(1, 0, 1, 0); step();
    knobs(0, 0, 1, 2); step();
    k_ready = 1'b0; step();
    k_tgt = 32'h100; k_flush = 1'b1; step();
    knobs(0, 0, 1, 0); step();
    chk("drop_no_req", 32'(last_req), 32'd0);
    step(); step();
    chk("redirect_valid", 32'(valid_o), 32'd1);
    chk("redirect_pc", pc_o, 32'h100);

    // Flush coincident with rvalid and decode stall.
    knobs(0, 0, 1, 0); step();
    knobs(1, 1, 1, 0); k_tgt = 32'h200; step();
    chk("flush_rv_valid", 32'(valid_o), 32'd0);
    chk("flush_rv_instr", instr_o, 32'h0000_0013);
    knobs(0, 0, 0, 0); step();
    chk("flush_rv_sreq", 32'(last_req), 32'd1);

    // Reset while waiting; late response lands in first post-reset cycle.
    knobs(0, 0, 1, 2); step();
    k_ready = 1'b0; step();
    do_reset();
    knobs(0, 0, 0, 0); k_unsol = 1'b1; step();
    chk("post_rst_ignore", 32'(valid_o), 32'd0);
    chk("post_rst_req", 32'(last_req), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      k_flush = ($urandom_range(0, 11) == 0);
      k_tgt   = 32'($urandom_range(0, 1023)) << 2;
      k_stall = ($urandom_range(0, 2) == 0);
      k_ready = ($urandom_range(0, 3) != 0);
      k_lat   = $urandom_range(0, 3);
      k_unsol = ($urandom_range(0, 3) == 0);
      step();
    end

    // Drain: everything fetched must come out.
    knobs(0, 0, 0, 0);
    for (int n = 0; n < 20 && (expq.size() > 0 || pend_v); n++) step();
    chk("drain_empty", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of PC, address and instruction words.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).
REQ-003 Clocking: one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 pc_i  input  DATA_WIDTH  current PC from the PC stage.
REQ-007 inc_pc_i  input  DATA_WIDTH  PC+4 from the PC stage.
REQ-008 pc_stall_o  output  1  high = PC register holds its value this cycle.
REQ-009 flush_i  input  1  taken branch/jump redirect from execute; PC loads target this cycle.
REQ-010 stall_i  input  1  decode cannot accept a new instruction.
REQ-011 imem_req_o  output  1  instruction cache read request.
REQ-012 imem_addr_o  output  DATA_WIDTH  request address (= pc_i).
REQ-013 imem_ready_i  input  1  cache accepts request this cycle.
REQ-014 imem_rvalid_i  input  1  read data valid.
REQ-015 imem_rdata_i  input  DATA_WIDTH  instruction word.
REQ-016 valid_o  output  1  IF/ID register holds a live instruction.
REQ-017 instr_o, pc_o, inc_pc_o  output  DATA_WIDTH each  IF/ID instruction, its PC, its PC+4.

Function
REQ-018 FSM states SHALL be S_REQ, S_WAIT, S_FULL, S_DROP; at most one request outstanding.
REQ-019 S_REQ: imem_req_o = !flush_i; imem_addr_o = pc_i; on req&&ready latch pc_i/inc_pc_i into an in-flight tag, go S_WAIT.
REQ-020 pc_stall_o SHALL be low only when (imem_req_o && imem_ready_i) or flush_i; high otherwise.
REQ-021 S_WAIT, rvalid, no flush: if !stall_i or !valid_o load rdata+tag into IF/ID, valid_o=1, go S_REQ; else store into one-entry skid buffer, go S_FULL.
REQ-022 S_FULL: imem_req_o=0; when !stall_i move buffer into IF/ID (valid_o=1), go S_REQ.
REQ-023 Flush in S_WAIT without rvalid SHALL go S_DROP; S_DROP discards the next rvalid then goes S_REQ; imem_req_o=0 in S_DROP.
REQ-024 Flush coincident with rvalid in S_WAIT SHALL discard the data and go S_REQ.
REQ-025 Flush in S_FULL SHALL invalidate the buffer and go S_REQ.
REQ-026 Flush in any state SHALL clear valid_o and set instr_o=NOP_INSTR on the next edge; flush has priority over stall_i.
REQ-027 When !stall_i and no instruction is delivered, valid_o SHALL drop to 0 (bubble, instr_o=NOP_INSTR).
REQ-028 When stall_i and valid_o, IF/ID outputs SHALL hold unchanged.
REQ-029 Latency: request accepted at edge N, rvalid at N+k (k>=1), valid_o high after edge N+k; zero-wait-state cache gives one instruction per cycle.
REQ-030 Unsolicited imem_rvalid_i in S_REQ or S_FULL SHALL be ignored.

Reset
REQ-031 On rst: state=S_REQ, valid_o=0, instr_o=NOP_INSTR, pc_o=0, inc_pc_o=0, skid buffer invalid, imem_req_o=0, pc_stall_o=1.
REQ-032 rst mid-request SHALL abandon the outstanding request; responses arriving in the first S_REQ cycle after reset are ignored.

Structure
REQ-033 Shared package SHALL hold the FSM state enum and NOP_INSTR.
REQ-034 IF/ID output register (load/hold/flush) SHALL be a sub-module if_id_reg; FSM and skid buffer stay in if_stage.

Verification
REQ-035 Zero-wait cache, pc_i 0,4,8 -> valid_o high on consecutive cycles, instr/pc pairs match, pc_stall_o low each cycle.
REQ-036 rvalid 3 cycles after accept at pc_i=0x10 -> pc_stall_o high 3 cycles, instr_o=mem[0x10], pc_o=0x10, inc_pc_o=0x14.
REQ-037 stall_i held 4 cycles with instruction at 0x20 arriving -> S_FULL, outputs hold 0x1C entry; after release 0x20 appears, no loss/duplication.
REQ-038 flush_i while waiting on 0x30, target 0x100 -> 0x30 data discarded, next valid_o has pc_o=0x100.
REQ-039 flush_i coincident with rvalid and stall_i -> valid_o=0, instr_o=0x00000013, state S_REQ.
REQ-040 rst asserted in S_WAIT -> all outputs at reset values next cycle, late rvalid ignored.
